// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the processor's data-memory port, on the dmem
// clock domain. A synchronous backing RAM occupies the bottom of the word
// address space. A small I/O page sits at the top of that space and holds a
// free-running timer, an LED register and a byte-wide transmit FIFO that
// drains over a valid/ready stream.
//
// Read data is registered, so q follows address by exactly one clock. Every
// read returns the state as it was before the edge that samples it, which
// gives read-first behaviour for the RAM and the I/O registers alike.
//
// Ports
//   clock    in   1   rising-edge clock for every register
//   reset    in   1   asynchronous, active-low; 0 clears all state except RAM
//   address  in  12   processor word address
//   data     in  32   store data
//   wren     in   1   store enable for this edge
//   q        out 32   registered read data
//   tx_valid out  1   transmit FIFO head is valid
//   tx_data  out  8   transmit FIFO head byte (0 while empty)
//   tx_ready in   1   consumer takes the head on an edge with tx_valid high
//   led      out 32   LED register contents
//
// I/O page (word addresses)
//   0xFF0 TIMER    read: counter, write: load counter
//   0xFF1 TX_DATA  write: push data[7:0], read: 0
//   0xFF2 STATUS   read: {count[2:0], overflow, full, empty} in bits [5:0]
//                  write: data[2]=1 clears overflow
//   0xFF3 LED      read/write
//   RAM_WORDS..0xFEF and 0xFF4..0xFFF read as 0 and ignore writes.
//
// RAM_WORDS must not exceed 3840, so the RAM never reaches the I/O page.
// FIFO_DEPTH must be a power of two and at least 2.

module dmem_responder #(
  parameter int RAM_WORDS  = 3840,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] led
);

  // FIFO pointer and occupancy widths. The count needs one bit more than
  // the pointers so that a full FIFO can be told apart from an empty one.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [12:0]      RAM_LIMIT = 13'(RAM_WORDS);

  localparam logic [11:0] ADDR_TIMER  = 12'hFF0;
  localparam logic [11:0] ADDR_TXDATA = 12'hFF1;
  localparam logic [11:0] ADDR_STATUS = 12'hFF2;
  localparam logic [11:0] ADDR_LED    = 12'hFF3;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic inRam;
  logic selTimer;
  logic selTx;
  logic selStatus;
  logic selLed;

  // The compare is one bit wider than the address so that the limit value
  // can reach 0x1000 without overflowing.
  assign inRam     = ({1'b0, address} < RAM_LIMIT);
  assign selTimer  = (address == ADDR_TIMER);
  assign selTx     = (address == ADDR_TXDATA);
  assign selStatus = (address == ADDR_STATUS);
  assign selLed    = (address == ADDR_LED);

  // ---------------------------------------------------------------------
  // Backing RAM
  // ---------------------------------------------------------------------
  // The RAM is deliberately left without a reset so that it maps onto a
  // block RAM. The read register samples the old word when a write to the
  // same address lands on the same edge, which makes the RAM read-first.
  // The RAM read is taken on every cycle. Its result is only used when the
  // registered select says the access was a RAM access.
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ramRd_q;

  always_ff @(posedge clock) begin
    if (wren && inRam) begin
      ram[address] <= data;
    end
    ramRd_q <= ram[address];
  end

  // ---------------------------------------------------------------------
  // Timer and LED register
  // ---------------------------------------------------------------------
  logic [31:0] timer_q, timer_d;
  logic [31:0] led_q, led_d;

  // A load from the processor wins over the increment on that edge. The
  // count then resumes from the loaded value on the following edge.
  always_comb begin
    timer_d = timer_q + 32'd1;
    led_d   = led_q;
    if (wren && selTimer) begin
      timer_d = data;
    end
    if (wren && selLed) begin
      led_d = data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      led_q   <= '0;
    end else begin
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic fifoEmpty;
  logic fifoFull;
  logic pushReq;
  logic pushAccept;
  logic popAccept;
  logic ovfSet;
  logic ovfClr;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FIFO_FULL);
  assign popAccept = !fifoEmpty && tx_ready;
  assign pushReq   = wren && selTx;

  // A push into a full FIFO still fits when the head leaves on the same
  // edge. Only a push that truly has no room is dropped and flagged.
  assign pushAccept = pushReq && (!fifoFull || popAccept);
  assign ovfSet     = pushReq && fifoFull && !popAccept;
  assign ovfClr     = wren && selStatus && data[2];

  // Pointers wrap on their own because the depth is a power of two. The
  // occupancy count is unchanged when a push and a pop share an edge.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pushAccept) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (popAccept) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({pushAccept, popAccept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // When a clear and a new overflow arrive on the same edge, the new
    // overflow wins so that the event is not lost.
    if (ovfClr) begin
      ovf_d = 1'b0;
    end
    if (ovfSet) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The storage needs no reset because the occupancy count alone decides
  // which entries are meaningful.
  always_ff @(posedge clock) begin
    if (pushAccept) begin
      fifoMem[wrPtr_q] <= data[7:0];
    end
  end

  // Both outputs come from registers only, so they change only on edges
  // and also drop to zero at once when reset is asserted. There is no
  // bypass path: a push into an empty FIFO becomes visible on the next edge.
  assign tx_valid = !fifoEmpty;
  assign tx_data  = fifoEmpty ? 8'h00 : fifoMem[rdPtr_q];

  // ---------------------------------------------------------------------
  // Read-data path
  // ---------------------------------------------------------------------
  logic [31:0] status;
  logic [31:0] regRd_q, regRd_d;
  logic        selRam_q, selRam_d;

  assign status = {26'b0, 3'(count_q), ovf_q, fifoFull, fifoEmpty};

  // The register side of the read mux uses only the present state. A read
  // that shares an edge with a write therefore returns the value from before
  // that write.
  always_comb begin
    regRd_d  = '0;
    selRam_d = inRam;
    case (address)
      ADDR_TIMER:  regRd_d = timer_q;
      ADDR_STATUS: regRd_d = status;
      ADDR_LED:    regRd_d = led_q;
      default:     regRd_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regRd_q  <= '0;
      selRam_q <= 1'b0;
    end else begin
      regRd_q  <= regRd_d;
      selRam_q <= selRam_d;
    end
  end

  // After reset the select chooses the register side, which is also cleared,
  // so q reads 0 at once even though the RAM read register holds stale data.
  assign q = selRam_q ? ramRd_q : regRd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//
// Directed bench for dmem_responder. Inputs are driven 1 time unit after a
// rising edge, and outputs are sampled at that same point, away from the
// edge. Every expected value is hand-computed in the test tasks.

module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] led;

  int nChecks;
  int nFails;

  // STATUS layout: bit0 empty, bit1 full, bit2 overflow, bits[5:3] count.
  localparam logic [31:0] ST_EMPTY    = 32'h01;
  localparam logic [31:0] ST_FULL     = 32'h22;
  localparam logic [31:0] ST_FULL_OVF = 32'h26;

  dmem_responder #(.RAM_WORDS(3840), .FIFO_DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .led      (led)
  );

  // Clock with a 10-unit period. The first rising edge is at time 5.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one access for exactly one edge, then drop the write enable.
  // On return, q holds the read result for the address just presented.
  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d, input logic w);
    address = a;
    data    = d;
    wren    = w;
    @(posedge clock);
    #1;
    wren    = 1'b0;
  endtask

  // Outputs must clear while reset is held, and the FIFO must come up empty.
  task automatic test_reset;
    reset    = 1'b0;
    address  = 12'hF80;
    data     = '0;
    wren     = 1'b0;
    tx_ready = 1'b0;
    #3;
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_q: got %h, required %h", q, 32'h0);
    end
    nChecks++;
    if ({tx_valid, tx_data} !== 9'h0) begin
      nFails++;
      $display("[TB] FAIL reset_tx: got valid=%b data=%h, required 0/00", tx_valid, tx_data);
    end
    nChecks++;
    if (led !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_led: got %h, required %h", led, 32'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_EMPTY) begin
      nFails++;
      $display("[TB] FAIL reset_status: got %h, required %h", q, ST_EMPTY);
    end
  endtask

  // Timer counts from reset release, supports a load, and wraps.
  task automatic test_timer;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    // Ten idle edges move the counter from 0 to 10.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(12'hF80, '0, 1'b0);
    end
    applyStimulus(12'hFF0, '0, 1'b0);
    nChecks++;
    if (q !== 32'd10) begin
      nFails++;
      $display("[TB] FAIL timer_edge10: got %h, required %h", q, 32'd10);
    end
    // A read that shares an edge with a write returns the count from
    // before the write.
    applyStimulus(12'hFF0, 32'hFFFF_FFFE, 1'b1);
    nChecks++;
    if (q !== 32'd11) begin
      nFails++;
      $display("[TB] FAIL timer_rdw: got %h, required %h", q, 32'd11);
    end
    applyStimulus(12'hFF0, '0, 1'b0);
    nChecks++;
    if (q !== 32'hFFFF_FFFE) begin
      nFails++;
      $display("[TB] FAIL timer_load: got %h, required %h", q, 32'hFFFF_FFFE);
    end
    applyStimulus(12'hFF0, '0, 1'b0);
    nChecks++;
    if (q !== 32'hFFFF_FFFF) begin
      nFails++;
      $display("[TB] FAIL timer_max: got %h, required %h", q, 32'hFFFF_FFFF);
    end
    applyStimulus(12'hFF0, '0, 1'b0);
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL timer_wrap: got %h, required %h", q, 32'h0);
    end
  endtask

  // RAM write then read, and a read-first access on a shared edge.
  task automatic test_ram;
    applyStimulus(12'h020, 32'h11, 1'b1);
    applyStimulus(12'h010, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(12'h010, '0, 1'b0);
    nChecks++;
    if (q !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("[TB] FAIL ram_read: got %h, required %h", q, 32'hDEAD_BEEF);
    end
    applyStimulus(12'h020, 32'h22, 1'b1);
    nChecks++;
    if (q !== 32'h11) begin
      nFails++;
      $display("[TB] FAIL ram_read_first: got %h, required %h", q, 32'h11);
    end
    applyStimulus(12'h020, '0, 1'b0);
    nChecks++;
    if (q !== 32'h22) begin
      nFails++;
      $display("[TB] FAIL ram_new_value: got %h, required %h", q, 32'h22);
    end
  endtask

  // Fill the FIFO to full, overflow it once, then clear the overflow flag.
  task automatic test_fifo_fill;
    logic [7:0] bytes [5];
    bytes[0] = 8'h41;
    bytes[1] = 8'h42;
    bytes[2] = 8'h43;
    bytes[3] = 8'h44;
    bytes[4] = 8'h45;
    tx_ready = 1'b0;
    nChecks++;
    if (tx_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL fill_empty_valid: got %b, required 0", tx_valid);
    end
    applyStimulus(12'hFF1, {24'h0, bytes[0]}, 1'b1);
    nChecks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
      nFails++;
      $display("[TB] FAIL fill_first_head: got valid=%b data=%h, required 1/41", tx_valid, tx_data);
    end
    for (int i = 1; i < 4; i++) begin
      applyStimulus(12'hFF1, {24'h0, bytes[i]}, 1'b1);
    end
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_FULL) begin
      nFails++;
      $display("[TB] FAIL fill_status_full: got %h, required %h", q, ST_FULL);
    end
    applyStimulus(12'hFF1, {24'h0, bytes[4]}, 1'b1);
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_FULL_OVF) begin
      nFails++;
      $display("[TB] FAIL fill_status_ovf: got %h, required %h", q, ST_FULL_OVF);
    end
    nChecks++;
    if (tx_data !== 8'h41) begin
      nFails++;
      $display("[TB] FAIL fill_head_stable: got %h, required %h", tx_data, 8'h41);
    end
    applyStimulus(12'hFF2, 32'h4, 1'b1);
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_FULL) begin
      nFails++;
      $display("[TB] FAIL fill_ovf_clear: got %h, required %h", q, ST_FULL);
    end
  endtask

  // Drain the full FIFO: one byte per edge, in order.
  task automatic test_fifo_drain;
    logic [7:0] expect_bytes [4];
    expect_bytes[0] = 8'h41;
    expect_bytes[1] = 8'h42;
    expect_bytes[2] = 8'h43;
    expect_bytes[3] = 8'h44;
    address  = 12'hF80;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if ({tx_valid, tx_data} !== {1'b1, expect_bytes[i]}) begin
        nFails++;
        $display("[TB] FAIL drain_byte%0d: got valid=%b data=%h, required 1/%h",
                 i, tx_valid, tx_data, expect_bytes[i]);
      end
      @(posedge clock);
      #1;
    end
    nChecks++;
    if (tx_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL drain_valid_low: got %b, required 0", tx_valid);
    end
    tx_ready = 1'b0;
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_EMPTY) begin
      nFails++;
      $display("[TB] FAIL drain_status: got %h, required %h", q, ST_EMPTY);
    end
  endtask

  // A push into a full FIFO on the same edge as a pop is accepted.
  task automatic test_back_to_back;
    logic [7:0] expect_bytes [4];
    expect_bytes[0] = 8'h52;
    expect_bytes[1] = 8'h53;
    expect_bytes[2] = 8'h54;
    expect_bytes[3] = 8'h55;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(12'hFF1, 32'h51 + 32'(i), 1'b1);
    end
    tx_ready = 1'b1;
    applyStimulus(12'hFF1, 32'h55, 1'b1);
    tx_ready = 1'b0;
    nChecks++;
    if (tx_data !== 8'h52) begin
      nFails++;
      $display("[TB] FAIL b2b_head: got %h, required %h", tx_data, 8'h52);
    end
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_FULL) begin
      nFails++;
      $display("[TB] FAIL b2b_status: got %h, required %h", q, ST_FULL);
    end
    address  = 12'hF80;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if ({tx_valid, tx_data} !== {1'b1, expect_bytes[i]}) begin
        nFails++;
        $display("[TB] FAIL b2b_byte%0d: got valid=%b data=%h, required 1/%h",
                 i, tx_valid, tx_data, expect_bytes[i]);
      end
      @(posedge clock);
      #1;
    end
    tx_ready = 1'b0;
    nChecks++;
    if (tx_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL b2b_drained: got %b, required 0", tx_valid);
    end
  endtask

  // Asynchronous reset while data is queued, then unmapped addresses.
  task automatic test_reset_midstream;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(12'hFF1, 32'h61 + 32'(i), 1'b1);
    end
    applyStimulus(12'hFF3, 32'h5, 1'b1);
    applyStimulus(12'hFF3, '0, 1'b0);
    nChecks++;
    if (q !== 32'h5) begin
      nFails++;
      $display("[TB] FAIL mid_led_read: got %h, required %h", q, 32'h5);
    end
    #2;
    reset = 1'b0;
    #1;
    nChecks++;
    if ({tx_valid, tx_data} !== 9'h0) begin
      nFails++;
      $display("[TB] FAIL mid_tx_cleared: got valid=%b data=%h, required 0/00", tx_valid, tx_data);
    end
    nChecks++;
    if (led !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL mid_led_cleared: got %h, required %h", led, 32'h0);
    end
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL mid_q_cleared: got %h, required %h", q, 32'h0);
    end
    #1;
    reset = 1'b1;
    applyStimulus(12'hFF2, '0, 1'b0);
    nChecks++;
    if (q !== ST_EMPTY) begin
      nFails++;
      $display("[TB] FAIL mid_status: got %h, required %h", q, ST_EMPTY);
    end

    // Unmapped space reads 0, and writes to it disturb nothing.
    applyStimulus(12'hFF3, 32'hA, 1'b1);
    applyStimulus(12'hF80, '0, 1'b0);
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL unmapped_read: got %h, required %h", q, 32'h0);
    end
    applyStimulus(12'hF80, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(12'hFF4, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(12'hF80, '0, 1'b0);
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL unmapped_after_write: got %h, required %h", q, 32'h0);
    end
    applyStimulus(12'hFF4, '0, 1'b0);
    nChecks++;
    if (q !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL unmapped_ff4: got %h, required %h", q, 32'h0);
    end
    applyStimulus(12'hFF3, '0, 1'b0);
    nChecks++;
    if (q !== 32'hA) begin
      nFails++;
      $display("[TB] FAIL unmapped_led_intact: got %h, required %h", q, 32'hA);
    end
    applyStimulus(12'h010, '0, 1'b0);
    nChecks++;
    if (q !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("[TB] FAIL unmapped_ram_intact: got %h, required %h", q, 32'hDEAD_BEEF);
    end
    nChecks++;
    if (tx_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL unmapped_no_push: got %b, required 0", tx_valid);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    test_reset();
    test_timer();
    test_ram();
    test_fifo_fill();
    test_fifo_drain();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
